// File: rtl/adat_vevo_pkg.sv
// Shared constants for the ADAT_VEVO 16-QAM symbol receiver: checker state
// encoding, PRBS-7 taps and default block parameters.
package adat_vevo_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } chk_state_e;

  // PRBS-7, x^7 + x^6 + 1: next bit = lfsr[6] ^ lfsr[5], newest bit in lfsr[0].
  localparam int PRBS_LEN    = 7;
  localparam int PRBS_TAP_A  = 6;
  localparam int PRBS_TAP_B  = 5;

  localparam int WIN_BITS    = 6;

  localparam int DEF_SYM_BITS = 4;
  localparam int DEF_LOCK_CNT = 16;
  localparam int DEF_LOSS_ERR = 4;

endpackage

// File: rtl/adat_vevo_prbs7_check.sv
// PRBS-7 stream checker: HUNT fills the LFSR, SYNC confirms LOCK_CNT matches,
// LOCKED free-runs the LFSR and counts bit errors with a 64-bit loss window.
module prbs7_check
  import adat_vevo_pkg::*;
#(
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_ERR = DEF_LOSS_ERR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        bit_valid,
  input  logic        rx_bit,
  input  logic        err_clr,
  output logic        lock,
  output logic [15:0] err_cnt,
  output chk_state_e  state_dbg
);

  localparam int MATCH_W = $clog2(LOCK_CNT);
  localparam int WERR_W  = $clog2(LOSS_ERR + 1);
  localparam logic [2:0]         FILL_LAST  = 3'(PRBS_LEN - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [WERR_W:0]    LOSS_LIM   = (WERR_W + 1)'(LOSS_ERR);

  chk_state_e                state_q, state_d;
  logic [PRBS_LEN-1:0]       lfsr_q, lfsr_d;
  logic [2:0]                fill_q, fill_d;
  logic [MATCH_W-1:0]        match_q, match_d;
  logic [WIN_BITS-1:0]       win_q, win_d;
  logic [WERR_W-1:0]         werr_q, werr_d;
  logic [WERR_W:0]           werr_sum;
  logic [15:0]               err_q, err_d;
  logic                      lock_q;
  logic                      pred;
  logic                      mism;
  logic                      err_hit;

  always_comb begin
    pred     = lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B];
    mism     = rx_bit ^ pred;
    werr_sum = {1'b0, werr_q} + {{WERR_W{1'b0}}, mism};
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    fill_d   = fill_q;
    match_d  = match_q;
    win_d    = win_q;
    werr_d   = werr_q;
    err_hit  = 1'b0;
    if (bit_valid) begin
      case (state_q)
        ST_HUNT: begin
          lfsr_d = {lfsr_q[PRBS_LEN-2:0], rx_bit};
          if (fill_q == FILL_LAST) begin
            state_d = ST_SYNC;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        ST_SYNC: begin
          lfsr_d = {lfsr_q[PRBS_LEN-2:0], rx_bit};
          if (mism) begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end else if (match_q == MATCH_LAST) begin
            state_d = ST_LOCKED;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          // Once locked the received bit no longer steers the LFSR.
          lfsr_d  = {lfsr_q[PRBS_LEN-2:0], pred};
          win_d   = win_q + 1'b1;
          err_hit = mism;
          if (werr_sum >= LOSS_LIM) begin
            state_d = ST_HUNT;
            fill_d  = '0;
          end else if (win_q == {WIN_BITS{1'b1}}) begin
            werr_d = '0;
          end else begin
            werr_d = werr_sum[WERR_W-1:0];
          end
        end
        default: begin
          state_d = ST_HUNT;
          fill_d  = '0;
        end
      endcase
    end
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (err_hit && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HUNT;
      lfsr_q  <= '0;
      fill_q  <= '0;
      match_q <= '0;
      win_q   <= '0;
      werr_q  <= '0;
      err_q   <= '0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      win_q   <= win_d;
      werr_q  <= werr_d;
      err_q   <= err_d;
      lock_q  <= (state_q == ST_LOCKED);
    end
  end

  assign lock      = lock_q;
  assign err_cnt   = err_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/adat_vevo.sv
// ADAT_VEVO receiver top: serial-to-symbol deserializer plus PRBS-7 lock checker.
// data_change is a valid-only strobe (no ready): every high cycle consumes exactly one adat_be bit.
module adat_vevo
  import adat_vevo_pkg::*;
#(
  parameter int SYM_BITS = DEF_SYM_BITS,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int LOSS_ERR = DEF_LOSS_ERR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                adat_be,
  input  logic                data_change,
  input  logic                err_clr,
  output logic [SYM_BITS-1:0] symbol,
  output logic                symbol_valid,
  output logic                lock,
  output logic [15:0]         err_cnt,
  output chk_state_e          state_dbg
);

  localparam int CNT_W = $clog2(SYM_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_BITS - 1);

  logic [SYM_BITS-2:0] sr_q;
  logic [SYM_BITS-1:0] sr_d;
  logic [CNT_W-1:0]    bit_cnt_q;

  assign sr_d = {sr_q, adat_be};

  // Framing runs purely on strobes; checker lock state never realigns it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      symbol       <= '0;
      symbol_valid <= 1'b0;
    end else begin
      symbol_valid <= 1'b0;
      if (data_change) begin
        sr_q <= sr_d[SYM_BITS-2:0];
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_q    <= '0;
          symbol       <= sr_d;
          symbol_valid <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end

  prbs7_check #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_ERR (LOSS_ERR)
  ) u_check (
    .clock     (clock),
    .reset     (reset),
    .bit_valid (data_change),
    .rx_bit    (adat_be),
    .err_clr   (err_clr),
    .lock      (lock),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

endmodule

// File: doc/adat_vevo.md
ADAT_VEVO -- requirements
Module: adat_vevo

Interface
REQ-001 Parameter SYM_BITS, default 4, bits per QAM symbol (16-QAM).
REQ-002 Parameter LOCK_CNT, default 16, consecutive matching bits required for lock.
REQ-003 Parameter LOSS_ERR, default 4, errors within one 64-bit window that force loss of lock.
REQ-004 clock  input  1  system clock, all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 adat_be  input  1  serial data bit from the data generator.
REQ-007 data_change  input  1  one-clock strobe; adat_be is valid and consumed in this cycle.
REQ-008 err_clr  input  1  synchronous clear of err_cnt.
REQ-009 symbol  output  SYM_BITS  last assembled symbol, first received bit in MSB.
REQ-010 symbol_valid  output  1  one-clock pulse, symbol updated.
REQ-011 lock  output  1  high while the checker FSM is in LOCKED.
REQ-012 err_cnt  output  16  saturating count of bit errors detected in LOCKED.

Function
REQ-013 A bit is accepted only in cycles where data_change=1; adat_be is ignored otherwise.
REQ-014 Accepted bits shift into a SYM_BITS-wide register, MSB first; a modulo-SYM_BITS bit counter starts at 0 after reset.
REQ-015 On the accepted bit that brings the counter to SYM_BITS-1, symbol is loaded with the complete word and symbol_valid pulses on the next clock edge (latency 1 clock).
REQ-016 symbol holds its value between pulses; symbol_valid is never high on two consecutive cycles unless data_change was high on two consecutive cycles.
REQ-017 The checker predicts bits with PRBS-7, polynomial x^7+x^6+1, in a 7-bit LFSR; predicted bit = LFSR[6] XOR LFSR[5].
REQ-018 FSM states: HUNT, SYNC, LOCKED; reset state HUNT.
REQ-019 HUNT: each accepted bit shifts into the LFSR; after 7 accepted bits, go to SYNC with match counter 0.
REQ-020 SYNC: the LFSR keeps being fed with the received bit; a match increments the match counter; a mismatch returns to HUNT with the fill counter cleared; reaching LOCK_CNT matches goes to LOCKED.
REQ-021 LOCKED: the LFSR free-runs on its own predicted bit, one step per accepted bit; each mismatch increments err_cnt and the window error counter.
REQ-022 LOCKED: a 6-bit window counter counts accepted bits; on wrap, the window error counter clears; when the window error counter reaches LOSS_ERR, go to HUNT.
REQ-023 err_cnt saturates at 16'hFFFF and is held in HUNT and SYNC.
REQ-024 err_clr=1 zeroes err_cnt; if an error coincides with err_clr, the clear wins and the result is 0.
REQ-025 lock is registered and follows the state with 1 clock latency after the transition edge.
REQ-026 Symbol framing is independent of the FSM; a loss of lock does not realign symbols.

Reset
REQ-027 reset=0 asynchronously sets symbol=0, symbol_valid=0, lock=0, err_cnt=0, LFSR=0, all counters=0, state=HUNT.
REQ-028 Reset asserted mid-symbol or mid-lock discards partial data; the first accepted bit after release is symbol bit MSB and HUNT bit 0.

Structure
REQ-029 A shared package holds the FSM state encoding, the PRBS-7 tap constants and the default SYM_BITS/LOCK_CNT/LOSS_ERR values, used by generator and receiver alike.
REQ-030 The PRBS checker (LFSR, FSM, error counters) is the sub-module prbs7_check; the deserializer stays in adat_vevo.

Verification
REQ-031 Generator-to-receiver loopback, data_change every 2nd clock, 200 bits -> lock=1 after 23 accepted bits (7+16), err_cnt=0 at end.
REQ-032 Serial bits 1,0,1,1 with strobes -> symbol=4'b1011 with a symbol_valid pulse exactly 1 clock after the 4th strobe.
REQ-033 Locked stream with a single bit flipped at bit 100 -> err_cnt=1, lock stays 1.
REQ-034 Locked stream with 4 flipped bits within 20 bits -> err_cnt=4, lock=0 within 2 clocks of the 4th error, relock after 23 further clean bits.
REQ-035 err_clr asserted in the same cycle as an error -> err_cnt=0 next cycle; err_cnt preset near 16'hFFFF with more errors -> holds 16'hFFFF.
REQ-036 reset pulsed low for 1 clock while locked, mid-symbol -> all outputs 0 immediately, next symbol_valid only after 4 new strobes.
